// File: rtl/jedro_1_mem_arbiter_pkg.sv
// Shared types for the jedro_1 fetch/load-store memory arbiter.
// A response tag records who owns an in-flight RAM access and whether it was a store.
package jedro_1_mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   is_store;
  } resp_tag_t;

  localparam resp_tag_t   TAG_IDLE     = '{owner: OWN_NONE, is_store: 1'b0};
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/jedro_1_mem_arbiter_if.sv
// Bundle of fetch, load/store and RAM-side signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/RAM view.
interface jedro_1_mem_arbiter_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 10
);
  logic                      if_req_i;
  logic [ADDR_WIDTH-1:0]     if_addr_i;
  logic                      if_gnt_o;
  logic                      if_rvalid_o;
  logic [DATA_WIDTH-1:0]     if_rdata_o;

  logic                      dm_req_i;
  logic                      dm_we_i;
  logic [DATA_WIDTH/8-1:0]   dm_be_i;
  logic [ADDR_WIDTH-1:0]     dm_addr_i;
  logic [DATA_WIDTH-1:0]     dm_wdata_i;
  logic                      dm_gnt_o;
  logic                      dm_rvalid_o;
  logic [DATA_WIDTH-1:0]     dm_rdata_o;

  logic                      ram_en_o;
  logic [DATA_WIDTH/8-1:0]   ram_we_o;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_WIDTH-1:0]     ram_wdata_o;
  logic [DATA_WIDTH-1:0]     ram_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/jedro_1_mem_arbiter_resp_pipe.sv
// Delay line carrying the owner tag of each granted access until its RAM data is valid.
// Synchronous reset drops every tag in flight.
module jedro_1_arb_resp_pipe
  import jedro_1_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  resp_tag_t tag_i,
  output resp_tag_t tag_o
);

  resp_tag_t stage_q [DEPTH];
  resp_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= TAG_IDLE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Single-port RAM arbiter between jedro_1 instruction fetch and load/store.
// Data has priority; a bounded counter forces a fetch grant after STARVE_LIMIT data grants.
module jedro_1_mem_arbiter
  import jedro_1_mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 10,
  parameter int unsigned RAM_LATENCY    = 1,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input logic clk_i,
  input logic rst_i,
  jedro_1_mem_arbiter_if.slave bus
);

  localparam int unsigned             BE_W  = DATA_WIDTH / 8;
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    if_gnt, dm_gnt;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [BE_W-1:0]         store_be;
  logic                    unused_addr_bits;
  resp_tag_t               tag_in, tag_out;

  // Grants are forced low in reset so every output reads 0 while rst_i is high.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst_i) begin
      if_gnt = bus.if_req_i & (~bus.dm_req_i | (starve_cnt_q == LIMIT));
      dm_gnt = bus.dm_req_i & ~if_gnt;
    end

    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req_i || if_gnt) begin
      starve_cnt_d = '0;
    end else if (dm_gnt && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    tag_in = TAG_IDLE;
    if (if_gnt) begin
      tag_in.owner = OWN_IF;
    end else if (dm_gnt) begin
      tag_in.owner    = OWN_DM;
      tag_in.is_store = bus.dm_we_i;
    end

    req_addr         = if_gnt ? bus.if_addr_i : bus.dm_addr_i;
    unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2]};
    store_be         = (dm_gnt && bus.dm_we_i) ? bus.dm_be_i : '0;

    bus.if_gnt_o    = if_gnt;
    bus.dm_gnt_o    = dm_gnt;
    bus.ram_en_o    = if_gnt | dm_gnt;
    bus.ram_we_o    = store_be;
    bus.ram_addr_o  = (if_gnt | dm_gnt) ? req_addr[RAM_ADDR_WIDTH+1:2] : '0;
    bus.ram_wdata_o = (dm_gnt && bus.dm_we_i) ? bus.dm_wdata_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  jedro_1_arb_resp_pipe #(
    .DEPTH(RAM_LATENCY)
  ) u_resp_pipe (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );

  always_comb begin
    bus.if_rvalid_o = 1'b0;
    bus.if_rdata_o  = '0;
    bus.dm_rvalid_o = 1'b0;
    bus.dm_rdata_o  = '0;
    if (!rst_i) begin
      case (tag_out.owner)
        OWN_IF: begin
          bus.if_rvalid_o = 1'b1;
          bus.if_rdata_o  = bus.ram_rdata_i;
        end
        OWN_DM: begin
          bus.dm_rvalid_o = 1'b1;
          if (!tag_out.is_store) bus.dm_rdata_o = bus.ram_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Self-checking bench for jedro_1_mem_arbiter: RAM model plus a request-level reference
// model (word memory, per-port request queues, in-order response scoreboard).
module tb_jedro_1_mem_arbiter;
  localparam int unsigned DW = 32, AW = 32, RAW = 10, LAT = 1, LIMIT = 4, WORDS = 1024;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  always #5 clk = ~clk;

  jedro_1_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW)) bus ();

  jedro_1_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW),
    .RAM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  // Bench RAM: one-cycle read latency, byte writes, preload word[i] = A000_0000 + i.
  logic [DW-1:0] ram_mem [WORDS];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) ram_mem[i] <= 32'hA000_0000 + i;
      bus.ram_rdata_i <= '0;
    end else if (bus.ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_o[b]) ram_mem[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      bus.ram_rdata_i <= ram_mem[bus.ram_addr_o];
    end
  end

  typedef struct {
    int unsigned   due;
    bit            is_if;
    logic [DW-1:0] data;
  } resp_t;

  typedef struct {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } dm_req_t;

  logic [DW-1:0] model_mem [WORDS];
  resp_t         sb[$];
  logic [AW-1:0] if_q[$];
  dm_req_t       dm_q[$];
  logic [DW-1:0] if_log[$], dm_log[$];
  int unsigned   if_log_cyc[$], dm_log_cyc[$];
  string         gnt_log;
  logic [RAW-1:0] last_ram_addr;
  bit            if_active, dm_active, random_gaps;
  int unsigned   cyc, streak;
  int            n_checks, n_fail;

  task automatic clear_logs();
    if_log.delete(); dm_log.delete(); if_log_cyc.delete(); dm_log_cyc.delete();
    gnt_log = "";
  endtask

  task automatic drive();
    if (!if_active && if_q.size() > 0 && (!random_gaps || $urandom_range(0, 3) != 0)) if_active = 1'b1;
    if (!dm_active && dm_q.size() > 0 && (!random_gaps || $urandom_range(0, 3) != 0)) dm_active = 1'b1;
    bus.if_req_i  = if_active;
    bus.if_addr_i = if_active ? if_q[0] : $urandom;
    bus.dm_req_i  = dm_active;
    if (dm_active) begin
      bus.dm_we_i = dm_q[0].we; bus.dm_be_i = dm_q[0].be;
      bus.dm_addr_i = dm_q[0].addr; bus.dm_wdata_i = dm_q[0].wdata;
    end else begin
      bus.dm_we_i = 1'($urandom); bus.dm_be_i = 4'($urandom);
      bus.dm_addr_i = $urandom; bus.dm_wdata_i = $urandom;
    end
  endtask

  // Reference model step, evaluated mid-cycle (negedge) against the DUT outputs.
  task automatic monitor();
    bit ex_if_v, ex_dm_v, e_if, e_dm, g_if, g_dm;
    logic [DW-1:0] ex_if_d, ex_dm_d, ev;
    logic [AW-1:0] a;
    int unsigned w;
    resp_t r;
    dm_req_t d;
    if (bus.if_rvalid_o === 1'b1) begin if_log.push_back(bus.if_rdata_o); if_log_cyc.push_back(cyc); end
    if (bus.dm_rvalid_o === 1'b1) begin dm_log.push_back(bus.dm_rdata_o); dm_log_cyc.push_back(cyc); end
    if (rst) begin
      n_checks++;
      if ({bus.if_gnt_o, bus.if_rvalid_o, bus.if_rdata_o, bus.dm_gnt_o, bus.dm_rvalid_o, bus.dm_rdata_o,
           bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_wdata_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d: gnt if/dm=%b%b rvalid if/dm=%b%b ram_en=%b ram_we=%h ram_addr=%h, required all 0",
                 cyc, bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o, bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o);
      end
      sb.delete();
      streak = 0;
      return;
    end

    ex_if_v = 0; ex_if_d = '0; ex_dm_v = 0; ex_dm_d = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      if (r.is_if) begin ex_if_v = 1; ex_if_d = r.data; end
      else begin ex_dm_v = 1; ex_dm_d = r.data; end
    end
    n_checks++;
    if ({bus.if_rvalid_o, bus.if_rdata_o} !== {ex_if_v, ex_if_d}) begin
      n_fail++;
      $display("FAIL if_resp cyc=%0d: got rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
               cyc, bus.if_rvalid_o, bus.if_rdata_o, ex_if_v, ex_if_d);
    end
    n_checks++;
    if ({bus.dm_rvalid_o, bus.dm_rdata_o} !== {ex_dm_v, ex_dm_d}) begin
      n_fail++;
      $display("FAIL dm_resp cyc=%0d: got rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
               cyc, bus.dm_rvalid_o, bus.dm_rdata_o, ex_dm_v, ex_dm_d);
    end

    // Rule: data wins unless fetch has already waited through LIMIT consecutive data grants.
    e_if = bus.if_req_i && (!bus.dm_req_i || streak == LIMIT);
    e_dm = bus.dm_req_i && !e_if;
    n_checks++;
    if ({bus.if_gnt_o, bus.dm_gnt_o} !== {e_if, e_dm}) begin
      n_fail++;
      $display("FAIL grant cyc=%0d: got if/dm=%b%b, required %b%b (streak %0d)",
               cyc, bus.if_gnt_o, bus.dm_gnt_o, e_if, e_dm, streak);
    end
    if (e_if || e_dm) begin
      a = e_if ? bus.if_addr_i : bus.dm_addr_i;
      w = (a >> 2) % WORDS;
      n_checks++;
      if ({bus.ram_en_o, bus.ram_addr_o} !== {1'b1, RAW'(w)}) begin
        n_fail++;
        $display("FAIL ram_addr cyc=%0d: got en=%b addr=%h, required en=1 addr=%h", cyc, bus.ram_en_o, bus.ram_addr_o, RAW'(w));
      end
      n_checks++;
      if (bus.ram_we_o !== ((e_dm && bus.dm_we_i) ? bus.dm_be_i : 4'b0)) begin
        n_fail++;
        $display("FAIL ram_we cyc=%0d: got %b", cyc, bus.ram_we_o);
      end
      if (e_dm && bus.dm_we_i) begin
        n_checks++;
        if (bus.ram_wdata_o !== bus.dm_wdata_i) begin
          n_fail++;
          $display("FAIL ram_wdata cyc=%0d: got %h, required %h", cyc, bus.ram_wdata_o, bus.dm_wdata_i);
        end
      end
    end else begin
      n_checks++;
      if ({bus.ram_en_o, bus.ram_we_o} !== 5'b0) begin
        n_fail++;
        $display("FAIL ram_idle cyc=%0d: got en=%b we=%b, required 0", cyc, bus.ram_en_o, bus.ram_we_o);
      end
    end
    last_ram_addr = bus.ram_addr_o;

    g_if = (bus.if_gnt_o === 1'b1) && bus.if_req_i;
    g_dm = (bus.dm_gnt_o === 1'b1) && bus.dm_req_i;
    if (g_if) begin
      w = (if_q[0] >> 2) % WORDS;
      sb.push_back('{due: cyc + LAT, is_if: 1'b1, data: model_mem[w]});
      void'(if_q.pop_front());
      if_active = 1'b0;
      gnt_log = {gnt_log, "I"};
      streak = 0;
    end else if (g_dm) begin
      d = dm_q.pop_front();
      w = (d.addr >> 2) % WORDS;
      if (d.we) begin
        for (int b = 0; b < 4; b++) if (d.be[b]) model_mem[w][8*b +: 8] = d.wdata[8*b +: 8];
        ev = '0;
      end else begin
        ev = model_mem[w];
      end
      sb.push_back('{due: cyc + LAT, is_if: 1'b0, data: ev});
      dm_active = 1'b0;
      gnt_log = {gnt_log, "D"};
      streak = bus.if_req_i ? streak + 1 : 0;
    end else begin
      gnt_log = {gnt_log, "-"};
      if (!bus.if_req_i) streak = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int unsigned max_cycles);
    int unsigned n = 0;
    while ((if_q.size() > 0 || dm_q.size() > 0 || sb.size() > 0) && n < max_cycles) begin
      drive();
      step();
      n++;
    end
    n_checks++;
    if (if_q.size() + dm_q.size() + sb.size() != 0) begin
      n_fail++;
      $display("FAIL run_timeout: %0d requests/responses outstanding after %0d cycles, required 0",
               if_q.size() + dm_q.size() + sb.size(), max_cycles);
      if_q.delete(); dm_q.delete(); sb.delete();
      if_active = 0; dm_active = 0;
    end
    bus.if_req_i = 1'b0;
    bus.dm_req_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; preload = 1'b1;
    for (int i = 0; i < WORDS; i++) model_mem[i] = 32'hA000_0000 + i;
    repeat (4) begin
      bus.if_req_i = 1'b1; bus.if_addr_i = $urandom;
      bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_be_i = 4'hF;
      bus.dm_addr_i = $urandom; bus.dm_wdata_i = $urandom;
      step();
    end
    bus.if_req_i = 1'b0; bus.dm_req_i = 1'b0;
    rst = 1'b0; preload = 1'b0;
    step();
  endtask

  task automatic test_fetch_stream();
    clear_logs();
    if_q.push_back(32'h0); if_q.push_back(32'h4); if_q.push_back(32'h8);
    run(20);
    n_checks++;
    if (gnt_log.substr(0, 2) != "III") begin
      n_fail++; $display("FAIL fetch_b2b: grant pattern %s, required III", gnt_log);
    end
    n_checks++;
    if (if_log.size() != 3 || if_log[0] !== 32'hA000_0000 || if_log[1] !== 32'hA000_0001 || if_log[2] !== 32'hA000_0002) begin
      n_fail++; $display("FAIL fetch_data: got %p, required A0000000 A0000001 A0000002", if_log);
    end
  endtask

  task automatic test_store_load();
    clear_logs();
    dm_q.push_back('{we: 1'b1, be: 4'b0011, addr: 32'h10, wdata: 32'hDEAD_BEEF});
    dm_q.push_back('{we: 1'b0, be: 4'b0000, addr: 32'h10, wdata: 32'h0});
    run(20);
    n_checks++;
    if (dm_log.size() != 2 || dm_log[0] !== 32'h0 || dm_log[1] !== 32'hA000_BEEF) begin
      n_fail++; $display("FAIL store_load: got %p, required 00000000 A000BEEF", dm_log);
    end
  endtask

  task automatic test_starvation();
    clear_logs();
    for (int i = 0; i < 12; i++) begin
      dm_q.push_back('{we: 1'b0, be: 4'h0, addr: 32'(i * 4), wdata: 32'h0});
      if (i < 4) if_q.push_back(32'(64 + i * 4));
    end
    run(60);
    n_checks++;
    if (gnt_log.substr(0, 11) != "DDDDIDDDDIDD") begin
      n_fail++; $display("FAIL starvation: grant pattern %s, required prefix DDDDIDDDDIDD", gnt_log);
    end
  endtask

  task automatic test_simultaneous();
    int unsigned c0;
    clear_logs();
    c0 = cyc;
    dm_q.push_back('{we: 1'b0, be: 4'h0, addr: 32'h20, wdata: 32'h0});
    if_q.push_back(32'h24);
    run(20);
    n_checks++;
    if (dm_log.size() != 1 || dm_log[0] !== 32'hA000_0008 || dm_log_cyc[0] != c0 + 1) begin
      n_fail++; $display("FAIL simul_dm: got %p, required A0000008 at cycle %0d", dm_log, c0 + 1);
    end
    n_checks++;
    if (if_log.size() != 1 || if_log[0] !== 32'hA000_0009 || if_log_cyc[0] != c0 + 2) begin
      n_fail++; $display("FAIL simul_if: got %p, required A0000009 at cycle %0d", if_log, c0 + 2);
    end
  endtask

  task automatic test_reset_drop();
    clear_logs();
    dm_q.push_back('{we: 1'b0, be: 4'h0, addr: 32'h30, wdata: 32'h0});
    drive();
    step();
    bus.dm_req_i = 1'b0; bus.if_req_i = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    n_checks++;
    if (dm_log.size() != 0) begin
      n_fail++; $display("FAIL reset_drop: got %0d dm responses, required 0", dm_log.size());
    end
    if_q.push_back(32'h8);
    run(10);
    n_checks++;
    if (if_log.size() != 1 || if_log[0] !== 32'hA000_0002) begin
      n_fail++; $display("FAIL post_reset: got %p, required A0000002", if_log);
    end
  endtask

  task automatic test_wrap();
    logic [RAW-1:0] got_addr;
    clear_logs();
    if_q.push_back(32'h1004);
    drive();
    step();
    got_addr = last_ram_addr;
    run(10);
    n_checks++;
    if (got_addr !== 10'd1 || if_log.size() != 1 || if_log[0] !== 32'hA000_0001) begin
      n_fail++; $display("FAIL wrap: got ram_addr=%0d data=%p, required ram_addr=1 data A0000001", got_addr, if_log);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    random_gaps = 1'b1;
    for (int i = 0; i < 120; i++) begin
      a = 32'($urandom_range(0, 15) << 2) | ($urandom & 32'h3) | ($urandom_range(0, 1) != 0 ? ($urandom & 32'hFFFF_F000) : 32'h0);
      if (i < 80) if_q.push_back(a);
      a = 32'($urandom_range(0, 15) << 2) | ($urandom & 32'h3) | ($urandom_range(0, 1) != 0 ? ($urandom & 32'hFFFF_F000) : 32'h0);
      dm_q.push_back('{we: 1'($urandom), be: 4'($urandom), addr: a, wdata: $urandom});
    end
    run(3000);
    random_gaps = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; streak = 0;
    if_active = 0; dm_active = 0; random_gaps = 0; gnt_log = "";
    test_reset();
    test_fetch_stream();
    test_store_load();
    test_starvation();
    test_simultaneous();
    test_reset_drop();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
